// File: rtl/repeat_edge_h_stream.sv
// Horizontal repeat-edge padder: PAD_L copies of each row's first pixel, the row, then PAD_R copies of its last pixel.
// Latency: 1 cycle from input handshake to out_valid; 1 pixel/cycle sustained.
// Backpressure: a stalled output holds every out register; in_ready falls while stalled or while replicas are emitted.
// Optional: REPEAT_EDGE_FRAME_CNT_EN adds a 16-bit frame_cnt output counting out_eof handshakes.
module repeat_edge_h_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int PAD_L  = 1,
    parameter int PAD_R  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof
`ifdef REPEAT_EDGE_FRAME_CNT_EN
   ,output logic [15:0]       frame_cnt
`endif
);

    localparam int OW    = PAD_L + IMG_W + PAD_R;
    localparam int COL_W = $clog2(OW + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);

    localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(OW - 1);
    localparam logic [COL_W-1:0] C_LREP_LAST = COL_W'(PAD_L);
    localparam logic [COL_W-1:0] C_BODY_END  = COL_W'(PAD_L + IMG_W);
    localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {S_FIRST, S_LREP, S_BODY, S_RREP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [DATA_W-1:0]   r_edge;
    logic [DATA_W-1:0]   r_out_dat;
    logic                r_out_vld;
    logic                r_out_sof;
    logic                r_out_eol;
    logic                r_out_eof;

    logic                w_slot_free;
    logic                w_load;
    logic                w_in_hs;
    logic [DATA_W-1:0]   w_load_dat;
    logic                w_col_last;
    logic [COL_W-1:0]    w_col_nxt;

    assign w_slot_free = !r_out_vld || out_ready;
    assign w_in_hs     = in_valid && in_ready;
    assign w_col_last  = (r_col == C_COL_LAST);
    assign w_col_nxt   = w_col_last ? '0 : r_col + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The state is a pure function of the column being entered.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            if (w_col_nxt == '0) begin
                w_state_nxt = S_FIRST;
            end else if (w_col_nxt <= C_LREP_LAST) begin
                w_state_nxt = S_LREP;
            end else if (w_col_nxt < C_BODY_END) begin
                w_state_nxt = S_BODY;
            end else begin
                w_state_nxt = S_RREP;
            end
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        w_load     = 1'b0;
        w_load_dat = r_edge;
        case (r_state)
            S_FIRST, S_BODY: begin
                in_ready   = w_slot_free;
                w_load     = in_valid && w_slot_free;
                w_load_dat = in_data;
            end
            default: begin
                w_load = w_slot_free;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_edge    <= '0;
            r_out_dat <= '0;
            r_out_vld <= 1'b0;
            r_out_sof <= 1'b0;
            r_out_eol <= 1'b0;
            r_out_eof <= 1'b0;
        end else if (w_load) begin
            r_out_dat <= w_load_dat;
            r_out_vld <= 1'b1;
            r_out_sof <= (r_row == '0) && (r_col == '0);
            r_out_eol <= w_col_last;
            r_out_eof <= w_col_last && (r_row == C_ROW_LAST);
            r_col     <= w_col_nxt;
            if (w_col_last) begin
                r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
            end
            if (w_in_hs) begin
                r_edge <= in_data;
            end
        end else if (w_slot_free) begin
            r_out_vld <= 1'b0;
        end
    end

    assign out_data  = r_out_dat;
    assign out_valid = r_out_vld;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;

`ifdef REPEAT_EDGE_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (r_out_vld && out_ready && r_out_eof) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
